// File: rtl/matrix_pkg.sv
// Shared types and constants for the display-matrix datapath.
package matrix_pkg;

    localparam int unsigned WORD_W = 14;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWait,
        StGap,
        StDone
    } seq_state_e;

endpackage

// File: rtl/upcntr.sv
// Generic N-bit up-counter with synchronous clear and count enable.
module upcntr #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + {{(N-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/display_word_sequencer.sv
// Walks the frame RAM word by word, handing each word to the serializer and
// waiting for it to be taken before moving on after a configurable idle gap.
module display_word_sequencer
    import matrix_pkg::*;
#(
    parameter int unsigned N_WORDS = 64,
    parameter int unsigned GAP     = 4,
    parameter int unsigned AW      = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              wrpulse,
    input  logic [WORD_W-1:0] rddata,
    output logic [AW-1:0]     rdaddr,
    output logic [WORD_W-1:0] chpdata,
    output logic              init,
    output logic              wrreset,
    output logic              busy,
    output logic              done
);

    localparam logic [AW-1:0] LastAddr = AW'(N_WORDS - 1);
    // GAP of 0 or 1 both spend a single cycle in StGap.
    localparam logic [3:0]    GapLast  = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    seq_state_e state_q;
    logic [3:0] gap_cnt;
    logic       gap_clr;
    logic       gap_en;
    logic       gap_last;

    assign gap_clr  = (state_q != StGap);
    assign gap_en   = (state_q == StGap);
    assign gap_last = (gap_cnt == GapLast);

    upcntr #(
        .N(4)
    ) u_gap_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (gap_clr),
        .en   (gap_en),
        .q    (gap_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            rdaddr  <= '0;
            chpdata <= '0;
            init    <= 1'b0;
            wrreset <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            init    <= 1'b0;
            wrreset <= 1'b0;
            done    <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                rdaddr  <= '0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q <= StFetch;
                            rdaddr  <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    StFetch: state_q <= StLoad;
                    // RAM data for rdaddr is valid now; present it with the load strobes.
                    StLoad: begin
                        chpdata <= rddata;
                        init    <= 1'b1;
                        wrreset <= 1'b1;
                        state_q <= StWait;
                    end
                    StWait: begin
                        if (wrpulse) begin
                            if (rdaddr == LastAddr) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                rdaddr  <= '0;
                            end else begin
                                state_q <= StGap;
                            end
                        end
                    end
                    StGap: begin
                        if (gap_last) begin
                            rdaddr  <= rdaddr + AW'(1);
                            state_q <= StFetch;
                        end
                    end
                    StDone:  state_q <= StIdle;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_word_sequencer.sv
// Randomized and directed bench for display_word_sequencer against a
// cycle-scheduling reference model (two instances: GAP=2/N=4 and GAP=0/N=5).
module tb_display_word_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  reset_w = 2'b00;
    logic [1:0]  start_w = 2'b00;
    logic [1:0]  abort_w = 2'b00;
    logic [1:0]  wrpulse_w = 2'b00;
    logic [13:0] rddata0, rddata1;
    logic [1:0]  rdaddr0;
    logic [2:0]  rdaddr1;
    logic [13:0] chp0, chp1;
    logic        init0, init1, wrreset0, wrreset1, busy0, busy1, done0, done1;

    logic [13:0] ram [2][8];

    display_word_sequencer #(.N_WORDS(4), .GAP(2)) dut0 (
        .clk(clk), .reset(reset_w[0]), .start(start_w[0]), .abort(abort_w[0]),
        .wrpulse(wrpulse_w[0]), .rddata(rddata0), .rdaddr(rdaddr0), .chpdata(chp0),
        .init(init0), .wrreset(wrreset0), .busy(busy0), .done(done0)
    );

    display_word_sequencer #(.N_WORDS(5), .GAP(0)) dut1 (
        .clk(clk), .reset(reset_w[1]), .start(start_w[1]), .abort(abort_w[1]),
        .wrpulse(wrpulse_w[1]), .rddata(rddata1), .rdaddr(rdaddr1), .chpdata(chp1),
        .init(init1), .wrreset(wrreset1), .busy(busy1), .done(done1)
    );

    // Synchronous frame RAMs: one cycle of read latency.
    always_ff @(posedge clk) begin
        rddata0 <= ram[0][rdaddr0];
        rddata1 <= ram[1][rdaddr1];
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state (expected outputs for the current cycle).
    bit          m_busy [2];
    bit          m_done [2];
    bit          m_init [2];
    bit          m_wait [2];
    int          m_addr [2];
    logic [13:0] m_chp  [2];
    int          init_at [2];
    int          inc_at  [2];

    // Stimulus requests and auto-responder.
    bit rq_start [2], rq_abort [2], rq_wr [2], rq_rst [2];
    int wr_delay [2];
    int wr_due   [2];

    // Observations of the DUTs.
    bit          dinit [2];
    int          dinit_addr [2];
    int          init_cnt [2];
    int          done_cnt [2];
    bit          done_busy [2];
    logic [13:0] seen0 [$];
    int          icyc1 [$];
    logic [13:0] nom [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic int nw(input int k);
        return (k == 0) ? 4 : 5;
    endfunction

    // Cycles actually spent idling between words: GAP, but at least one.
    function automatic int gp(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [20:0] obs(input int k);
        if (k == 0) return {busy0, done0, init0, wrreset0, 1'b0, rdaddr0, chp0};
        return {busy1, done1, init1, wrreset1, rdaddr1, chp1};
    endfunction

    function automatic logic [20:0] expv(input int k);
        return {m_busy[k], m_done[k], m_init[k], m_init[k], 3'(m_addr[k]), m_chp[k]};
    endfunction

    // Predict cycle cyc+1 from the inputs driven during cycle cyc.
    function automatic void advance(input int k, input bit rs, input bit st, input bit ab,
                                    input bit wr);
        int n1;
        bit idle;
        bit waiting;
        n1      = cyc + 1;
        idle    = !m_busy[k] && !m_done[k];
        waiting = m_wait[k];
        m_init[k] = 1'b0;
        m_done[k] = 1'b0;
        if (!rs || ab) begin
            m_busy[k]  = 1'b0;
            m_addr[k]  = 0;
            m_wait[k]  = 1'b0;
            init_at[k] = -1;
            inc_at[k]  = -1;
            if (!rs) m_chp[k] = '0;
        end else begin
            if (idle && st) begin
                m_busy[k]  = 1'b1;
                m_addr[k]  = 0;
                init_at[k] = n1 + 2;
            end
            if (waiting && wr) begin
                m_wait[k] = 1'b0;
                if (m_addr[k] == nw(k) - 1) begin
                    m_busy[k] = 1'b0;
                    m_done[k] = 1'b1;
                    m_addr[k] = 0;
                end else begin
                    inc_at[k]  = n1 + gp(k);
                    init_at[k] = n1 + gp(k) + 2;
                end
            end
            if (n1 == inc_at[k]) m_addr[k] = m_addr[k] + 1;
            if (n1 == init_at[k]) begin
                m_init[k] = 1'b1;
                m_chp[k]  = ram[k][m_addr[k]];
                m_wait[k] = 1'b1;
            end
        end
    endfunction

    task automatic step();
        bit wr;
        logic [20:0] o;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            check($sformatf("outs%0d", k), 32'(o), 32'(expv(k)));
            dinit[k] = o[18];
            dinit_addr[k] = int'(o[16:14]);
            if (o[18]) begin
                init_cnt[k]++;
                if (k == 0) seen0.push_back(o[13:0]);
                else icyc1.push_back(cyc);
            end
            if (o[19]) begin
                done_cnt[k]++;
                done_busy[k] = o[20];
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (m_init[k] && wr_delay[k] >= 0) wr_due[k] = cyc + wr_delay[k];
            wr = rq_wr[k] || (wr_due[k] == cyc);
            reset_w[k]   = !rq_rst[k];
            start_w[k]   = rq_start[k];
            abort_w[k]   = rq_abort[k];
            wrpulse_w[k] = wr;
            advance(k, !rq_rst[k], rq_start[k], rq_abort[k], wr);
            rq_start[k] = 1'b0;
            rq_abort[k] = 1'b0;
            rq_wr[k]    = 1'b0;
            rq_rst[k]   = 1'b0;
        end
    endtask

    task automatic wait_init(input int k, input int a, input int limit, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            step();
            hit = dinit[k] && (dinit_addr[k] == a);
        end
        if (!hit) check({tag, "_timeout"}, 32'(hit), 32'd1);
    endtask

    initial begin
        int d;
        int scyc;
        nom[0] = 14'h0001; nom[1] = 14'h0002; nom[2] = 14'h3FFF; nom[3] = 14'h2AAA;
        for (int i = 0; i < 8; i++) begin
            ram[0][i] = (i < 4) ? nom[i] : 14'h0;
            ram[1][i] = 14'($urandom);
        end
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_done[k] = 0; m_init[k] = 0; m_wait[k] = 0;
            m_addr[k] = 0; m_chp[k] = '0; init_at[k] = -1; inc_at[k] = -1;
            rq_start[k] = 0; rq_abort[k] = 0; rq_wr[k] = 0; rq_rst[k] = 1;
            wr_delay[k] = -1; wr_due[k] = -1;
            init_cnt[k] = 0; done_cnt[k] = 0; done_busy[k] = 0;
        end
        step();
        rq_rst[0] = 1; rq_rst[1] = 1;
        step();
        check("reset_state0", 32'(obs(0)), 32'd0);
        check("reset_state1", 32'(obs(1)), 32'd0);

        // Nominal frame on instance 0, serializer takes each word 5 cycles after init.
        seen0.delete();
        wr_delay[0] = 5;
        rq_start[0] = 1;
        step();
        for (int i = 0; i < 200 && done_cnt[0] == 0; i++) step();
        check("nom_done_count", 32'(done_cnt[0]), 32'd1);
        check("nom_busy_with_done", 32'(done_busy[0]), 32'd0);
        step();
        check("nom_done_one_cycle", 32'(done0), 32'd0);
        check("nom_words", 32'(seen0.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (seen0.size() > i) check($sformatf("nom_word%0d", i), 32'(seen0[i]), 32'(nom[i]));
        wr_delay[0] = -1;

        // Back-to-back on instance 1: GAP=0, word taken on the init cycle.
        icyc1.delete();
        d = done_cnt[1];
        wr_delay[1] = 0;
        rq_start[1] = 1;
        scyc = cyc + 1;
        step();
        for (int i = 0; i < 200 && done_cnt[1] == d; i++) step();
        check("b2b_inits", 32'(icyc1.size()), 32'd5);
        if (icyc1.size() > 0) check("b2b_latency", 32'(icyc1[0] - scyc), 32'd3);
        for (int i = 1; i < icyc1.size(); i++)
            check($sformatf("b2b_space%0d", i), 32'(icyc1[i] - icyc1[i-1]), 32'd4);
        wr_delay[1] = -1;
        repeat (3) step();

        // Abort while waiting on word 2, then replay from word 0.
        wr_delay[0] = 3;
        rq_start[0] = 1;
        step();
        wait_init(0, 2, 100, "abort_w2");
        wr_delay[0] = -1; wr_due[0] = -1;
        rq_abort[0] = 1;
        step();
        d = done_cnt[0];
        step();
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_addr", 32'(rdaddr0), 32'd0);
        check("abort_done", 32'(done0), 32'd0);
        repeat (5) step();
        check("abort_no_done", 32'(done_cnt[0]), 32'(d));
        rq_start[0] = 1;
        step();
        wait_init(0, 0, 20, "replay");
        check("replay_word0", 32'(chp0), 32'(ram[0][0]));
        rq_abort[0] = 1;
        step();
        step();

        // Stray wrpulse in FETCH/GAP and stray start in WAIT.
        rq_start[0] = 1;
        step();
        rq_wr[0] = 1;
        step();
        wait_init(0, 0, 20, "stray");
        rq_start[0] = 1; step();
        rq_start[0] = 1; step();
        check("stray_chp", 32'(chp0), 32'(ram[0][0]));
        check("stray_addr", 32'(rdaddr0), 32'd0);
        check("stray_busy", 32'(busy0), 32'd1);
        rq_wr[0] = 1; step();
        rq_wr[0] = 1; step();
        rq_wr[0] = 1; step();
        step();
        check("stray_gap_addr", 32'(rdaddr0), 32'd1);
        check("stray_gap_chp", 32'(chp0), 32'(ram[0][0]));
        wait_init(0, 1, 20, "stray_w1");
        check("stray_word1", 32'(chp0), 32'(ram[0][1]));

        // Reset for one cycle while in the gap after word 1.
        rq_wr[0] = 1; step();
        rq_rst[0] = 1; step();
        step();
        check("rst_outs", 32'(obs(0)), 32'd0);
        d = init_cnt[0];
        repeat (20) step();
        check("rst_no_init", 32'(init_cnt[0]), 32'(d));

        // Abort and wrpulse together on the last word.
        wr_delay[0] = 2;
        rq_start[0] = 1;
        step();
        wait_init(0, 3, 200, "simul");
        wr_delay[0] = -1; wr_due[0] = -1;
        rq_abort[0] = 1; rq_wr[0] = 1;
        step();
        d = done_cnt[0];
        step();
        check("simul_busy", 32'(busy0), 32'd0);
        check("simul_done", 32'(done0), 32'd0);
        repeat (4) step();
        check("simul_no_done", 32'(done_cnt[0]), 32'(d));

        // Random traffic on both instances.
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 2; k++) begin
                rq_start[k] = ($urandom_range(7) == 0);
                rq_abort[k] = ($urandom_range(63) == 0);
                rq_wr[k]    = ($urandom_range(2) == 0);
                rq_rst[k]   = ($urandom_range(255) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
